cdb_collector: RTL

- Host-side command intake stage that feeds the interface queue.
- Accepts a SCSI-style CDB as eight consecutive 32-bit rows and assembles them into one 256-bit command word.
- Holds assembled commands in a small FIFO and presents them downstream as cmd_out qualified by sq_select, with pop handshake cmd_ack.
- Also reports queue occupancy and protocol errors to the host side.

---
 rtl/cdb_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 65 ++++++
 rtl/cdb_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared constants, opcodes and FSM state type for the CDB intake path.
// The optional opcode filter in cdb_collector is enabled by CDB_OPCODE_CHECK_EN.
package cdb_pkg;

  localparam int CDB_ROWS  = 8;
  localparam int CDB_ROW_W = 32;
  localparam int CDB_W     = CDB_ROWS * CDB_ROW_W;

  localparam logic [7:0] OP_BSM_WRITE = 8'h40;
  localparam logic [7:0] OP_BSM_READ  = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } cdb_state_e;

  function automatic logic opcode_ok(input logic [7:0] op);
    return (op == OP_BSM_WRITE) || (op == OP_BSM_READ);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular DEPTH x WIDTH command FIFO with a registered head word that reads 0 when empty.
// Push is refused when full unless a pop happens in the same cycle.
module cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + AW'(do_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    head_next  = '0;
    count_next = count + CW'(do_push) - CW'(do_pop);
    if (count_next == '0)
      head_next = '0;
    else if (do_push && (count - CW'(do_pop)) == '0)
      head_next = data_in;  // new entry lands directly at the head
    else
      head_next = mem[rd_next];
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= count_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/cdb_collector.sv
// Assembles eight 32-bit CDB rows into a 256-bit command and queues it in cmd_fifo.
// Optional opcode filtering is compiled in with CDB_OPCODE_CHECK_EN.
module cdb_collector
  import cdb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int ROWS  = CDB_ROWS,
  parameter  int ROW_W = CDB_ROW_W,
  localparam int CMD_W = ROWS * ROW_W,
  localparam int RCW   = $clog2(ROWS),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmdq_select,
  input  logic [ROW_W-1:0] cmd_in,
  output logic             sq_select,
  output logic [CMD_W-1:0] cmd_out,
  input  logic             cmd_ack,
  output logic [CW-1:0]    cmdq_count,
  output logic             cmdq_full,
  output logic             cdb_error,
  output logic             overflow_sticky
);

  cdb_state_e       state;
  logic [RCW-1:0]   row_cnt;
  logic [RCW-1:0]   wr_idx;
  logic [CMD_W-1:0] rows;
  logic             empty, pop, room, op_ok, push;

  assign pop  = cmd_ack && sq_select;
  assign room = !cmdq_full || pop;

`ifdef CDB_OPCODE_CHECK_EN
  assign op_ok = opcode_ok(rows[7:0]);
`else
  assign op_ok = 1'b1;
`endif

  assign push      = (state == COMMIT) && op_ok && room;
  assign sq_select = !empty;
  assign wr_idx    = (state == COLLECT) ? row_cnt : '0;

  // Row buffer: IDLE and COMMIT both take row 0, so back-to-back CDBs need no gap.
  always_ff @(posedge clock) begin
    if (cmdq_select)
      rows[int'(wr_idx)*ROW_W +: ROW_W] <= cmd_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      row_cnt         <= '0;
      cdb_error       <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      cdb_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cmdq_select) begin
            row_cnt <= RCW'(1);
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (!cmdq_select) begin
            cdb_error <= 1'b1;  // truncated CDB, partial rows are abandoned
            row_cnt   <= '0;
            state     <= IDLE;
          end else if (row_cnt == RCW'(ROWS - 1)) begin
            row_cnt <= '0;
            state   <= COMMIT;
          end else begin
            row_cnt <= row_cnt + RCW'(1);
          end
        end
        COMMIT: begin
          if (!op_ok) begin
            cdb_error <= 1'b1;
          end else if (!room) begin
            cdb_error       <= 1'b1;
            overflow_sticky <= 1'b1;
          end
          if (cmdq_select) begin
            row_cnt <= RCW'(1);
            state   <= COLLECT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .data_in (rows),
    .pop     (pop),
    .head    (cmd_out),
    .count   (cmdq_count),
    .full    (cmdq_full),
    .empty   (empty)
  );

endmodule
